// File: rtl/proc_param_if.sv
// Handshake and bus signals between the board top-level and proc_param.
// The master side drives Run/DIN and observes Done, BusWires and Zero.
interface proc_param_if #(
  parameter int WIDTH = 16
);
  logic             Run;
  logic [WIDTH-1:0] DIN;
  logic             Done;
  logic [WIDTH-1:0] BusWires;
  logic             Zero;

  modport master (
    output Run,
    output DIN,
    input  Done,
    input  BusWires,
    input  Zero
  );

  modport slave (
    input  Run,
    input  DIN,
    output Done,
    output BusWires,
    output Zero
  );
endinterface

// File: rtl/proc_param.sv
// Parametrised multicycle processor: eight WIDTH-bit registers, 9-bit
// instructions (III XXX YYY) fetched from DIN in T0, one shared bus, and an
// A/G accumulator pair for the five ALU ops. Done, BusWires and Zero are
// decoded combinationally from the registered state.
module proc_param #(
  parameter int WIDTH = 16
) (
  input logic          Clock,
  input logic          Resetn,
  proc_param_if.slave  cpu
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } step_e;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_MVNZ = 3'b111;

  // ALU result for the G write in T2; arithmetic wraps modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] alu_f(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH-1:0] res;
    case (op)
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      default: res = '0;
    endcase
    return res;
  endfunction

  // State
  step_e            step_q, step_d;
  logic [8:0]       ir_q, ir_d;
  logic [WIDTH-1:0] r_q [8];
  logic [WIDTH-1:0] r_d [8];
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] g_q, g_d;

  // Decode
  logic [2:0]       op_s;
  logic [2:0]       x_s;
  logic [2:0]       y_s;
  logic             sel_din_s;
  logic             sel_g_s;
  logic             sel_rx_s;
  logic             sel_ry_s;
  logic             done_s;
  logic             ir_we_s;
  logic             a_we_s;
  logic             g_we_s;
  logic             rx_we_s;
  logic [WIDTH-1:0] bus_s;

  assign op_s = ir_q[8:6];
  assign x_s  = ir_q[5:3];
  assign y_s  = ir_q[2:0];

  // Step sequencing: bus source, write enables and Done for the current step.
  always_comb begin
    sel_din_s = 1'b0;
    sel_g_s   = 1'b0;
    sel_rx_s  = 1'b0;
    sel_ry_s  = 1'b0;
    done_s    = 1'b0;
    ir_we_s   = 1'b0;
    a_we_s    = 1'b0;
    g_we_s    = 1'b0;
    rx_we_s   = 1'b0;
    step_d    = step_q;
    case (step_q)
      T0: begin
        if (cpu.Run) begin
          ir_we_s = 1'b1;
          step_d  = T1;
        end else begin
          step_d  = T0;
        end
      end
      T1: begin
        case (op_s)
          OP_MV: begin
            sel_ry_s = 1'b1;
            rx_we_s  = 1'b1;
            done_s   = 1'b1;
            step_d   = T0;
          end
          OP_MVI: begin
            sel_din_s = 1'b1;
            rx_we_s   = 1'b1;
            done_s    = 1'b1;
            step_d    = T0;
          end
          OP_MVNZ: begin
            sel_ry_s = 1'b1;
            rx_we_s  = (g_q != '0);
            done_s   = 1'b1;
            step_d   = T0;
          end
          default: begin
            // ALU ops: latch the first operand into A.
            sel_rx_s = 1'b1;
            a_we_s   = 1'b1;
            step_d   = T2;
          end
        endcase
      end
      T2: begin
        sel_ry_s = 1'b1;
        g_we_s   = 1'b1;
        step_d   = T3;
      end
      T3: begin
        sel_g_s = 1'b1;
        rx_we_s = 1'b1;
        done_s  = 1'b1;
        step_d  = T0;
      end
      default: begin
        step_d = T0;
      end
    endcase
  end

  // Bus multiplexer: single source per step, 0 when nothing is selected.
  always_comb begin
    if (sel_din_s) begin
      bus_s = cpu.DIN;
    end else if (sel_g_s) begin
      bus_s = g_q;
    end else if (sel_rx_s) begin
      bus_s = r_q[x_s];
    end else if (sel_ry_s) begin
      bus_s = r_q[y_s];
    end else begin
      bus_s = '0;
    end
  end

  // Next-state values for IR, A, G and the register file.
  always_comb begin
    ir_d = ir_q;
    a_d  = a_q;
    g_d  = g_q;
    for (int i = 0; i < 8; i++) begin
      r_d[i] = r_q[i];
    end
    if (ir_we_s) begin
      ir_d = cpu.DIN[8:0];
    end else begin
      ir_d = ir_q;
    end
    if (a_we_s) begin
      a_d = bus_s;
    end else begin
      a_d = a_q;
    end
    if (g_we_s) begin
      g_d = alu_f(op_s, a_q, bus_s);
    end else begin
      g_d = g_q;
    end
    if (rx_we_s) begin
      r_d[x_s] = bus_s;
    end else begin
      r_d[x_s] = r_q[x_s];
    end
  end

  // State registers; Resetn clears everything immediately.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      step_q <= T0;
      ir_q   <= 9'd0;
      a_q    <= '0;
      g_q    <= '0;
      for (int i = 0; i < 8; i++) begin
        r_q[i] <= '0;
      end
    end else begin
      step_q <= step_d;
      ir_q   <= ir_d;
      a_q    <= a_d;
      g_q    <= g_d;
      for (int i = 0; i < 8; i++) begin
        r_q[i] <= r_d[i];
      end
    end
  end

  assign cpu.Done     = done_s;
  assign cpu.BusWires = bus_s;
  assign cpu.Zero     = (g_q == '0);

endmodule

// File: tb/tb_proc_param.sv
// Directed bench for proc_param (WIDTH=16). The driver pushes the hand-worked
// expected bus trace, Zero and latency of each instruction into a scoreboard;
// a negedge monitor pops and compares whenever the DUT raises Done.
module tb_proc_param;

  logic Clock;
  logic Resetn;

  proc_param_if #(.WIDTH(16)) cpu_if ();

  proc_param #(.WIDTH(16)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .cpu    (cpu_if)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    string            name;
    int               lat;
    logic [2:0][15:0] bus;
    logic             zero;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: tracks fetch/steps from Run and Done, compares against scoreboard.
  bit busy = 1'b0;
  int cycles = 0;
  always @(negedge Clock) begin
    if (!Resetn) begin
      busy   = 1'b0;
      cycles = 0;
    end else if (busy) begin
      cycles++;
      if (sb.size() > 0 && cycles >= 2 && cycles <= 4)
        chk($sformatf("%s_bus_t%0d", sb[0].name, cycles - 1),
            {16'd0, cpu_if.BusWires}, {16'd0, sb[0].bus[cycles-2]});
      if (cpu_if.Done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk($sformatf("%s_latency", e.name), cycles, e.lat);
          chk($sformatf("%s_zero", e.name), {31'd0, cpu_if.Zero}, {31'd0, e.zero});
        end
        busy = 1'b0;
      end else if (cycles > 8) begin
        chk("instr_hang", 32'd1, 32'd0);
        busy = 1'b0;
      end
    end else begin
      chk("idle_done", {31'd0, cpu_if.Done}, 32'd0);
      chk("idle_bus", {16'd0, cpu_if.BusWires}, 32'd0);
      if (cpu_if.Run) begin
        busy   = 1'b1;
        cycles = 1;
      end
    end
  end

  task automatic wait_done(input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge Clock);
      if (cpu_if.Done) seen = 1'b1;
    end
    chk($sformatf("%s_done_seen", nm), {31'd0, seen}, 32'd1);
    @(posedge Clock);
    #2;
  endtask

  // Issue one instruction starting in T0 (called at posedge+2).
  task automatic issue(input string nm, input logic [8:0] ins, input logic [15:0] imm,
                       input int lat, input logic [15:0] b0, input logic [15:0] b1,
                       input logic [15:0] b2, input logic z);
    exp_t e;
    e.name = nm;
    e.lat  = lat;
    e.bus  = {b2, b1, b0};
    e.zero = z;
    sb.push_back(e);
    cpu_if.DIN = {7'd0, ins};
    cpu_if.Run = 1'b1;
    @(posedge Clock);
    #2;
    cpu_if.Run = 1'b0;
    cpu_if.DIN = imm;
    wait_done(nm);
  endtask

  task automatic idle(input int n);
    cpu_if.Run = 1'b0;
    cpu_if.DIN = 16'h0081;
    repeat (n) @(posedge Clock);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    Resetn     = 1'b0;
    cpu_if.Run = 1'b0;
    cpu_if.DIN = 16'd0;
    #1;
    chk("por_bus", {16'd0, cpu_if.BusWires}, 32'd0);
    chk("por_done", {31'd0, cpu_if.Done}, 32'd0);
    chk("por_zero", {31'd0, cpu_if.Zero}, 32'd1);
    @(posedge Clock);
    @(posedge Clock);
    #2;
    Resetn = 1'b1;
    idle(2);

    // Build nonzero state, then reset in the middle of a sub.
    issue("pre_mvi_r0", 9'h040, 16'h0005, 2, 16'h0005, 16'h0000, 16'h0000, 1'b1);
    issue("pre_mvi_r1", 9'h048, 16'h0003, 2, 16'h0003, 16'h0000, 16'h0000, 1'b1);
    issue("pre_add",    9'h081, 16'h0000, 4, 16'h0005, 16'h0003, 16'h0008, 1'b0);
    cpu_if.DIN = 16'h00C1;
    cpu_if.Run = 1'b1;
    @(posedge Clock);
    #2;
    cpu_if.Run = 1'b0;
    @(posedge Clock);
    #3;
    chk("abort_t2_bus", {16'd0, cpu_if.BusWires}, 32'h0003);
    Resetn = 1'b0;
    #1;
    chk("rst_bus", {16'd0, cpu_if.BusWires}, 32'd0);
    chk("rst_done", {31'd0, cpu_if.Done}, 32'd0);
    chk("rst_zero", {31'd0, cpu_if.Zero}, 32'd1);
    @(posedge Clock);
    @(posedge Clock);
    #2;
    Resetn = 1'b1;
    idle(5);

    // Registers cleared by reset.
    issue("rst_mv_r2_r0", 9'h010, 16'h0000, 2, 16'h0000, 16'h0000, 16'h0000, 1'b1);
    issue("rst_mv_r2_r1", 9'h011, 16'h0000, 2, 16'h0000, 16'h0000, 16'h0000, 1'b1);

    // mvi / mv
    issue("mvi_r0_5",  9'h040, 16'h0005, 2, 16'h0005, 16'h0000, 16'h0000, 1'b1);
    issue("mvi_r1_3",  9'h048, 16'h0003, 2, 16'h0003, 16'h0000, 16'h0000, 1'b1);
    issue("mv_r2_r0",  9'h010, 16'h0000, 2, 16'h0005, 16'h0000, 16'h0000, 1'b1);

    // add / sub
    issue("add_r0_r1", 9'h081, 16'h0000, 4, 16'h0005, 16'h0003, 16'h0008, 1'b0);
    issue("sub_r0_r1", 9'h0C1, 16'h0000, 4, 16'h0008, 16'h0003, 16'h0005, 1'b0);

    // logic ops and Zero
    issue("mvi_r0_f0",  9'h040, 16'h00F0, 2, 16'h00F0, 16'h0000, 16'h0000, 1'b0);
    issue("mvi_r1_ff0", 9'h048, 16'h0FF0, 2, 16'h0FF0, 16'h0000, 16'h0000, 1'b0);
    issue("and_r0_r1",  9'h101, 16'h0000, 4, 16'h00F0, 16'h0FF0, 16'h00F0, 1'b0);
    issue("xor_r1_r1",  9'h189, 16'h0000, 4, 16'h0FF0, 16'h0FF0, 16'h0000, 1'b1);

    // mvnz with G==0 leaves R2 at 5
    issue("mvnz_g0",    9'h1D0, 16'h0000, 2, 16'h00F0, 16'h0000, 16'h0000, 1'b1);
    issue("mv_r5_r2_a", 9'h02A, 16'h0000, 2, 16'h0005, 16'h0000, 16'h0000, 1'b1);
    issue("or_r1_r0",   9'h148, 16'h0000, 4, 16'h0000, 16'h00F0, 16'h00F0, 1'b0);

    // mvnz with G==8 copies R0 into R2
    issue("mvi_r6_5",   9'h070, 16'h0005, 2, 16'h0005, 16'h0000, 16'h0000, 1'b0);
    issue("mvi_r7_3",   9'h078, 16'h0003, 2, 16'h0003, 16'h0000, 16'h0000, 1'b0);
    issue("add_r6_r7",  9'h0B7, 16'h0000, 4, 16'h0005, 16'h0003, 16'h0008, 1'b0);
    issue("mvnz_g8",    9'h1D0, 16'h0000, 2, 16'h00F0, 16'h0000, 16'h0000, 1'b0);
    issue("mv_r5_r2_b", 9'h02A, 16'h0000, 2, 16'h00F0, 16'h0000, 16'h0000, 1'b0);
    issue("mv_r2_r2",   9'h012, 16'h0000, 2, 16'h00F0, 16'h0000, 16'h0000, 1'b0);

    // wrap-around
    issue("mvi_r3_ffff", 9'h058, 16'hFFFF, 2, 16'hFFFF, 16'h0000, 16'h0000, 1'b0);
    issue("mvi_r4_1",    9'h060, 16'h0001, 2, 16'h0001, 16'h0000, 16'h0000, 1'b0);
    issue("add_wrap",    9'h09C, 16'h0000, 4, 16'hFFFF, 16'h0001, 16'h0000, 1'b1);
    issue("sub_wrap",    9'h0DC, 16'h0000, 4, 16'h0000, 16'h0001, 16'hFFFF, 1'b0);

    idle(3);
    chk("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
